// File: rtl/dec_sel_pkg.sv
// Shared types and sizes for the round-robin arbiter that feeds the 2-to-4 enable decoder.
package dec_sel_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

endpackage

// File: rtl/dec_sel_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// The lock line exists only when DEC_SEL_LOCK_EN is defined.
interface dec_sel_arbiter_if;
  import dec_sel_pkg::*;

  logic [N_REQ-1:0] req;
`ifdef DEC_SEL_LOCK_EN
  logic             lock;
`endif
  logic             grant_en;
  logic [SEL_W-1:0] grant_sel;
  logic             busy;

`ifdef DEC_SEL_LOCK_EN
  modport master (output req, output lock, input grant_en, input grant_sel, input busy);
  modport slave  (input req, input lock, output grant_en, output grant_sel, output busy);
`else
  modport master (output req, input grant_en, input grant_sel, input busy);
  modport slave  (input req, output grant_en, output grant_sel, output busy);
`endif

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request scanning last+1 .. last+4 (mod 4),
// so the most recently granted index always has the lowest priority.
module rr_pick4
  import dec_sel_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  // rot[k] is the request at index last+1+k; rot[0] has the highest priority
  logic [N_REQ-1:0] rot;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [SEL_W-1:0] pos;
      assign pos     = last + SEL_W'(gi + 1);
      assign rot[gi] = req[pos];
    end
  endgenerate

  always_comb begin
    any = |req;
    idx = last + SEL_W'(1);
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx = last + SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/dec_sel_arbiter.sv
// Round-robin arbiter driving the 2-to-4 enable decoder; one grant at a time, bounded hold,
// one idle cycle between grants. Optional DEC_SEL_LOCK_EN lets a lock input extend a grant.
module dec_sel_arbiter
  import dec_sel_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  dec_sel_arbiter_if.slave  bus
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] hold_reg, hold_next;
  logic [SEL_W-1:0] last_reg, last_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic             en_reg, en_next;
  logic             busy_reg, busy_next;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             granted_req;
  logic             grant_exit;

  rr_pick4 u_pick (
    .req  (bus.req),
    .last (last_reg),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign granted_req = bus.req[sel_reg];

`ifdef DEC_SEL_LOCK_EN
  assign grant_exit = !granted_req || (!bus.lock && (hold_reg == '0));
`else
  assign grant_exit = !granted_req || (hold_reg == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
      last_reg  <= SEL_W'(N_REQ - 1);
      sel_reg   <= '0;
      en_reg    <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      last_reg  <= last_next;
      sel_reg   <= sel_next;
      en_reg    <= en_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    last_next  = last_reg;
    sel_next   = sel_reg;
    en_next    = 1'b0;
    case (state_reg)
      IDLE, GAP: begin
        if (pick_any) begin
          state_next = GRANT;
          en_next    = 1'b1;
          sel_next   = pick_idx;
          hold_next  = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          state_next = IDLE;
        end
      end
      GRANT: begin
        if (grant_exit) begin
          state_next = GAP;
          last_next  = sel_reg;
        end else begin
          en_next = 1'b1;
          // saturates at zero so a locked grant can outlive its hold budget
          if (hold_reg != '0) begin
            hold_next = hold_reg - CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  assign bus.grant_en  = en_reg;
  assign bus.grant_sel = sel_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_dec_sel_arbiter.sv
// Directed bench for dec_sel_arbiter (HOLD_CYCLES=4 main instance, HOLD_CYCLES=1 side instance).
module tb_dec_sel_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dec_sel_arbiter_if bus ();
  dec_sel_arbiter_if bus1 ();

  dec_sel_arbiter #(.HOLD_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  dec_sel_arbiter #(.HOLD_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.grant_en !== 1'b0 || bus.busy !== 1'b0 || bus.grant_sel !== 2'b00) begin
      n_err++;
      $display("FAIL reset_state: en=%b busy=%b sel=%0d, expected en=0 busy=0 sel=0",
               bus.grant_en, bus.busy, bus.grant_sel);
    end
    bus.req = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (bus.grant_en !== 1'b0 || bus.busy !== 1'b0 || bus.grant_sel !== 2'b00) begin
        n_err++;
        $display("FAIL idle_quiet[%0d]: en=%b busy=%b sel=%0d, expected en=0 busy=0 sel=0",
                 i, bus.grant_en, bus.busy, bus.grant_sel);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_hold_one();
    int exp_sel[5] = '{0, -1, 1, -1, 0};
    bus1.req = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (exp_sel[i] < 0) begin
        if (bus1.grant_en !== 1'b0) begin
          n_err++;
          $display("FAIL hold_one_gap[%0d]: en=%b, expected en=0", i, bus1.grant_en);
        end
      end else if (bus1.grant_en !== 1'b1 || bus1.grant_sel !== 2'(exp_sel[i])) begin
        n_err++;
        $display("FAIL hold_one_grant[%0d]: en=%b sel=%0d, expected en=1 sel=%0d",
                 i, bus1.grant_en, bus1.grant_sel, exp_sel[i]);
      end
    end
    bus1.req = 4'b0000;
    tick();
    tick();
    $display("test_hold_one: done");
  endtask

  task automatic test_alternate();
    int exp_sel[14] = '{0, 0, 0, 0, -1, 2, 2, 2, 2, -1, 0, 0, 0, 0};
    bus.req = 4'b0101;
    for (int i = 0; i < 14; i++) begin
      tick();
      n_cmp++;
      if (exp_sel[i] < 0) begin
        if (bus.grant_en !== 1'b0 || bus.busy !== 1'b1) begin
          n_err++;
          $display("FAIL alt_gap[%0d]: en=%b busy=%b, expected en=0 busy=1",
                   i, bus.grant_en, bus.busy);
        end
      end else if (bus.grant_en !== 1'b1 || bus.grant_sel !== 2'(exp_sel[i]) || bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL alt_grant[%0d]: en=%b sel=%0d busy=%b, expected en=1 sel=%0d busy=1",
                 i, bus.grant_en, bus.grant_sel, bus.busy, exp_sel[i]);
      end
    end
    bus.req = 4'b0000;
    tick();
    tick();
    tick();
    $display("test_alternate: done");
  endtask

  task automatic test_drop();
    bus.req = 4'b1000;
    tick();
    tick();
    n_cmp++;
    if (bus.grant_en !== 1'b1 || bus.grant_sel !== 2'd3) begin
      n_err++;
      $display("FAIL drop_grant: en=%b sel=%0d, expected en=1 sel=3", bus.grant_en, bus.grant_sel);
    end
    bus.req = 4'b0000;
    tick();
    n_cmp++;
    if (bus.grant_en !== 1'b0 || bus.busy !== 1'b1 || bus.grant_sel !== 2'd3) begin
      n_err++;
      $display("FAIL drop_gap: en=%b busy=%b sel=%0d, expected en=0 busy=1 sel=3",
               bus.grant_en, bus.busy, bus.grant_sel);
    end
    tick();
    n_cmp++;
    if (bus.grant_en !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL drop_idle: en=%b busy=%b, expected en=0 busy=0", bus.grant_en, bus.busy);
    end
    $display("test_drop: done");
  endtask

  task automatic test_rotate_all();
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        n_cmp++;
        if (bus.grant_en !== 1'b1 || bus.grant_sel !== 2'(g % 4)) begin
          n_err++;
          $display("FAIL rotate_grant[%0d.%0d]: en=%b sel=%0d, expected en=1 sel=%0d",
                   g, c, bus.grant_en, bus.grant_sel, g % 4);
        end
      end
      tick();
      n_cmp++;
      if (bus.grant_en !== 1'b0) begin
        n_err++;
        $display("FAIL rotate_gap[%0d]: en=%b, expected en=0", g, bus.grant_en);
      end
    end
    bus.req = 4'b0000;
    $display("test_rotate_all: done");
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 10; i++) tick();
    tick();
    n_cmp++;
    if (bus.grant_en !== 1'b1 || bus.grant_sel !== 2'd2) begin
      n_err++;
      $display("FAIL midrst_pre: en=%b sel=%0d, expected en=1 sel=2", bus.grant_en, bus.grant_sel);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.grant_en !== 1'b0 || bus.busy !== 1'b0 || bus.grant_sel !== 2'd0) begin
      n_err++;
      $display("FAIL midrst_cut: en=%b busy=%b sel=%0d, expected en=0 busy=0 sel=0",
               bus.grant_en, bus.busy, bus.grant_sel);
    end
    tick();
    n_cmp++;
    if (bus.grant_en !== 1'b1 || bus.grant_sel !== 2'd0) begin
      n_err++;
      $display("FAIL midrst_first: en=%b sel=%0d, expected en=1 sel=0", bus.grant_en, bus.grant_sel);
    end
    bus.req = 4'b0000;
    tick();
    tick();
    $display("test_reset_mid_grant: done");
  endtask

`ifdef DEC_SEL_LOCK_EN
  task automatic test_lock();
    do_reset();
    bus.lock = 1'b1;
    bus.req  = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (bus.grant_en !== 1'b1 || bus.grant_sel !== 2'd1) begin
        n_err++;
        $display("FAIL lock_hold[%0d]: en=%b sel=%0d, expected en=1 sel=1",
                 i, bus.grant_en, bus.grant_sel);
      end
    end
    bus.lock = 1'b0;
    tick();
    n_cmp++;
    if (bus.grant_en !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL lock_release: en=%b busy=%b, expected en=0 busy=1", bus.grant_en, bus.busy);
    end
    bus.req = 4'b0000;
    tick();
    tick();
    $display("test_lock: done");
  endtask
`endif

  initial begin
    bus.req  = 4'b0000;
    bus1.req = 4'b0000;
`ifdef DEC_SEL_LOCK_EN
    bus.lock  = 1'b0;
    bus1.lock = 1'b0;
`endif
    test_reset();
    test_hold_one();
    test_alternate();
    test_drop();
    test_rotate_all();
    test_reset_mid_grant();
`ifdef DEC_SEL_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
